// File: rtl/exec_alu_stage.sv
// ----------------------------------------------------------------------------
// exec_alu_stage
//   Single-cycle RV32I integer execute stage. Decodes OP / OP-IMM instructions
//   into an ALU operation and operand select. Computes the result and registers
//   it together with the register-file writeback controls.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   inputs carry a valid instruction this cycle
//   inst       raw 32-bit instruction word
//   rs1_data   register-file read data for rs1
//   rs2_data   register-file read data for rs2
//   imm        sign-extended immediate
//   out_valid  registered: outputs belong to an accepted instruction
//   result     registered ALU result (0 for illegal instructions)
//   rd         registered destination register inst[11:7]
//   reg_write  registered register-file write enable
//   illegal    registered: accepted instruction is not a supported ALU op
// ----------------------------------------------------------------------------
module exec_alu_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic [31:0]     inst,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] imm,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [6:0] OPC_OP  = 7'b0110011;
    localparam logic [6:0] OPC_IMM = 7'b0010011;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
    } alu_op_e;

    function automatic logic [XLEN-1:0] alu_calc(input alu_op_e op,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        logic [4:0]             shamt;
        a_s   = $signed(a);
        b_s   = $signed(b);
        shamt = b[4:0];
        case (op)
            ALU_ADD:  alu_calc = a + b;
            ALU_SUB:  alu_calc = a - b;
            ALU_SLL:  alu_calc = a << shamt;
            ALU_SLT:  alu_calc = {{(XLEN-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: alu_calc = {{(XLEN-1){1'b0}}, (a < b)};
            ALU_XOR:  alu_calc = a ^ b;
            ALU_SRL:  alu_calc = a >> shamt;
            ALU_SRA:  alu_calc = $unsigned(a_s >>> shamt);
            ALU_OR:   alu_calc = a | b;
            ALU_AND:  alu_calc = a & b;
            default:  alu_calc = '0;
        endcase
    endfunction

    // ---- stage p0: decode, operand select, ALU ----
    logic [6:0]      opcode_p0;
    logic [2:0]      funct3_p0;
    logic [6:0]      funct7_p0;
    logic [4:0]      rd_p0;
    logic            is_op_p0;
    logic            is_imm_p0;
    logic            legal_p0;
    alu_op_e         alu_op_p0;
    logic [XLEN-1:0] op2_p0;
    logic [XLEN-1:0] result_p0;
    logic            unused_p0;

    assign opcode_p0 = inst[6:0];
    assign rd_p0     = inst[11:7];
    assign funct3_p0 = inst[14:12];
    assign funct7_p0 = inst[31:25];
    assign is_op_p0  = (opcode_p0 == OPC_OP);
    assign is_imm_p0 = (opcode_p0 == OPC_IMM);
    // Register-specifier fields are consumed by the register file, not here.
    assign unused_p0 = ^inst[24:15];

    always_comb begin
        legal_p0 = 1'b0;
        if (is_op_p0) begin
            legal_p0 = (funct7_p0 == F7_BASE) ||
                       ((funct7_p0 == F7_ALT) &&
                        ((funct3_p0 == 3'b000) || (funct3_p0 == 3'b101)));
        end else if (is_imm_p0) begin
            // funct7 only exists in OP-IMM shift encodings; elsewhere it is immediate bits.
            case (funct3_p0)
                3'b001:  legal_p0 = (funct7_p0 == F7_BASE);
                3'b101:  legal_p0 = (funct7_p0 == F7_BASE) || (funct7_p0 == F7_ALT);
                default: legal_p0 = 1'b1;
            endcase
        end
    end

    always_comb begin
        alu_op_p0 = ALU_ADD;
        case (funct3_p0)
            // ADDI never becomes SUB: its funct7 bits are part of the immediate.
            3'b000:  alu_op_p0 = (is_op_p0 && (funct7_p0 == F7_ALT)) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op_p0 = ALU_SLL;
            3'b010:  alu_op_p0 = ALU_SLT;
            3'b011:  alu_op_p0 = ALU_SLTU;
            3'b100:  alu_op_p0 = ALU_XOR;
            3'b101:  alu_op_p0 = (funct7_p0 == F7_ALT) ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op_p0 = ALU_OR;
            default: alu_op_p0 = ALU_AND;
        endcase
    end

    assign op2_p0    = is_imm_p0 ? imm : rs2_data;
    assign result_p0 = legal_p0 ? alu_calc(alu_op_p0, rs1_data, op2_p0) : '0;

    // ---- stage p1: output register ----
    logic            vld_p1;
    logic [XLEN-1:0] result_p1;
    logic [4:0]      rd_p1;
    logic            reg_write_p1;
    logic            illegal_p1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            result_p1    <= '0;
            rd_p1        <= '0;
            reg_write_p1 <= 1'b0;
            illegal_p1   <= 1'b0;
        end else begin
            vld_p1       <= in_valid;
            reg_write_p1 <= in_valid && legal_p0 && (rd_p0 != 5'd0);
            illegal_p1   <= in_valid && !legal_p0;
            // Data holds across bubbles so downstream sees a stable bus.
            if (in_valid) begin
                result_p1 <= result_p0;
                rd_p1     <= rd_p0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign result    = result_p1;
    assign rd        = rd_p1;
    assign reg_write = reg_write_p1;
    assign illegal   = illegal_p1;

endmodule

// File: tb/tb_exec_alu_stage.sv
// ----------------------------------------------------------------------------
// tb_exec_alu_stage
//   Directed-vector bench. The driver pushes one expected output record per
//   clock cycle into a queue; an independent monitor pops one record after each
//   rising edge and compares it with the registered DUT outputs.
// ----------------------------------------------------------------------------
module tb_exec_alu_stage;

    localparam logic [6:0] OP  = 7'b0110011;
    localparam logic [6:0] IMM = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] inst = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic [31:0] imm = '0;
    logic        out_valid;
    logic [31:0] result;
    logic [4:0]  rd;
    logic        reg_write;
    logic        illegal;

    exec_alu_stage #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .inst(inst),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm),
        .out_valid(out_valid), .result(result), .rd(rd),
        .reg_write(reg_write), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        vld;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        rw;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_pass = 0;
    logic [31:0] last_res = '0;
    logic [4:0]  last_rd = '0;

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rdi, input logic [6:0] opc);
        return {f7, 5'd2, 5'd1, f3, rdi, opc};
    endfunction

    task automatic chk(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s.%s actual=%h expected=%h", name, field, act, exp);
    endtask

    task automatic issue(input string name, input logic v, input logic [31:0] i,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic [31:0] er, input logic erw, input logic eill);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b1; in_valid = v; inst = i; rs1_data = a; rs2_data = b; imm = im;
        e.name = name;
        if (v) begin
            e.vld = 1'b1; e.res = er; e.rd = i[11:7]; e.rw = erw; e.ill = eill;
            last_res = er; last_rd = i[11:7];
        end else begin
            e.vld = 1'b0; e.res = last_res; e.rd = last_rd; e.rw = 1'b0; e.ill = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic rst_cycle(input string name);
        exp_t e;
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; inst = enc(7'h00, 3'b000, 5'd3, OP);
        rs1_data = 32'd5; rs2_data = 32'd7; imm = '0;
        e.name = name; e.vld = 1'b0; e.res = '0; e.rd = '0; e.rw = 1'b0; e.ill = 1'b0;
        last_res = '0; last_rd = '0;
        sb.push_back(e);
    endtask

    // Monitor: one record per clock, sampled 2 time units after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk(e.name, "out_valid", {31'd0, out_valid}, {31'd0, e.vld});
                chk(e.name, "result",    result,             e.res);
                chk(e.name, "rd",        {27'd0, rd},        {27'd0, e.rd});
                chk(e.name, "reg_write", {31'd0, reg_write}, {31'd0, e.rw});
                chk(e.name, "illegal",   {31'd0, illegal},   {31'd0, e.ill});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int waited;
        rst_cycle("reset0");
        rst_cycle("reset1");
        issue("add",    1, enc(7'h00, 3'b000, 5'd3, OP), 32'd5, 32'd7, 32'd0, 32'd12, 1, 0);
        issue("sub",    1, enc(7'h20, 3'b000, 5'd4, OP), 32'd0, 32'd1, 32'd0, 32'hFFFF_FFFF, 1, 0);
        issue("sra",    1, enc(7'h20, 3'b101, 5'd5, OP), 32'h8000_0000, 32'd4, 32'd0, 32'hF800_0000, 1, 0);
        issue("srl",    1, enc(7'h00, 3'b101, 5'd5, OP), 32'h8000_0000, 32'd4, 32'd0, 32'h0800_0000, 1, 0);
        issue("addi",   1, enc(7'h20, 3'b000, 5'd6, IMM), 32'd10, 32'd100, 32'hFFFF_FFFF, 32'd9, 1, 0);
        issue("slti",   1, enc(7'h00, 3'b010, 5'd6, IMM), 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd1, 1, 0);
        issue("sltiu",  1, enc(7'h00, 3'b011, 5'd6, IMM), 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd0, 1, 0);
        issue("slli",   1, enc(7'h00, 3'b001, 5'd7, IMM), 32'h4000_0001, 32'd0, 32'h21, 32'h8000_0002, 1, 0);
        issue("srai",   1, enc(7'h20, 3'b101, 5'd7, IMM), 32'h8000_0000, 32'd0, 32'h404, 32'hF800_0000, 1, 0);
        issue("ill_opc",1, enc(7'h00, 3'b000, 5'd7, 7'b0000011), 32'd5, 32'd7, 32'd0, 32'd0, 0, 1);
        issue("ill_f7", 1, enc(7'h01, 3'b000, 5'd8, OP), 32'd5, 32'd7, 32'd0, 32'd0, 0, 1);
        issue("ill_sli",1, enc(7'h20, 3'b001, 5'd9, IMM), 32'd5, 32'd0, 32'd1, 32'd0, 0, 1);
        issue("add_x0", 1, enc(7'h00, 3'b000, 5'd0, OP), 32'd2, 32'd3, 32'd0, 32'd5, 0, 0);
        issue("and",    1, enc(7'h00, 3'b111, 5'd8, OP), 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'h0000_00F0, 1, 0);
        issue("gap",    0, enc(7'h00, 3'b110, 5'd9, OP), 32'h1234_0000, 32'h0000_5678, 32'd0, 32'd0, 0, 0);
        issue("or",     1, enc(7'h00, 3'b110, 5'd9, OP), 32'h0000_F0F0, 32'h0000_0FF0, 32'd0, 32'h0000_FFF0, 1, 0);
        issue("xor",    1, enc(7'h00, 3'b100, 5'd10, OP), 32'hFF00_FF00, 32'h0FF0_0FF0, 32'd0, 32'hF0F0_F0F0, 1, 0);
        issue("slt",    1, enc(7'h00, 3'b010, 5'd11, OP), 32'h8000_0000, 32'd1, 32'd0, 32'd1, 1, 0);
        issue("sltu",   1, enc(7'h00, 3'b011, 5'd11, OP), 32'h8000_0000, 32'd1, 32'd0, 32'd0, 1, 0);
        issue("sll",    1, enc(7'h00, 3'b001, 5'd12, OP), 32'd3, 32'hFFFF_FFE4, 32'd0, 32'h0000_0030, 1, 0);
        rst_cycle("reset2");
        issue("idle",   0, enc(7'h00, 3'b000, 5'd13, OP), 32'd1, 32'd1, 32'd0, 32'd0, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        waited = 0;
        while (sb.size() > 0 && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        chk("drain", "pending", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/exec_alu_stage.md
# exec_alu_stage

Single-cycle integer execute stage for the hp_core RV32I datapath. It decodes the ALU-class instruction (R-type OP and I-type OP-IMM) into control signals and an ALU operation, selects the second operand, computes the result, and registers result plus writeback control for the register file. It combines main control, ALU control and the ALU behind one output register.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  inputs carry a valid instruction this cycle.
- inst  in  32  raw instruction word.
- rs1_data  in  32  register-file read data for rs1.
- rs2_data  in  32  register-file read data for rs2.
- imm  in  32  sign-extended immediate from the immediate generator.
- out_valid  out  1  registered; result/rd/flags belong to an accepted instruction.
- result  out  32  registered ALU output.
- rd  out  5  registered destination register, inst[11:7].
- reg_write  out  1  registered register-file write enable.
- illegal  out  1  registered; accepted instruction is not a supported ALU op.

## Operation
- Fields: opcode=inst[6:0], rd=inst[11:7], funct3=inst[14:12], funct7=inst[31:25].
- Main control: opcode 0110011 (OP) gives alu_src=0, op2=rs2_data. Opcode 0010011 (OP-IMM) gives alu_src=1, op2=imm. Any other opcode is illegal.
- ALU control by funct3:
  - 000: ADD. In OP with funct7=0100000 it is SUB. In OP-IMM, funct7 is ignored, so ADDI is always ADD.
  - 001: SLL.
  - 010: SLT, signed compare, result 1 or 0.
  - 011: SLTU, unsigned compare.
  - 100: XOR.
  - 101: SRL when funct7=0000000; SRA (arithmetic) when funct7=0100000. The same rule applies in OP-IMM.
  - 110: OR.
  - 111: AND.
- Illegal funct7 cases:
  - OP: any funct7 other than 0000000 is illegal, except 0100000 with funct3 000 or 101.
  - OP-IMM: funct3 001 requires funct7=0000000; funct3 101 requires funct7 0000000 or 0100000.
- Shift amount is op2[4:0]; upper bits are ignored.
- Arithmetic wraps modulo 2^32; there is no overflow flag.
- reg_write = in_valid AND legal AND rd != 0.
- Illegal instruction: result register loads 0, reg_write=0, illegal=1.

## Timing
- All outputs update on rising clk. Latency is 1 cycle from inputs to outputs; throughput is 1 instruction per cycle. There is no stall or backpressure.
- Reset (rst_n=0 at a clock edge): out_valid=0, result=0, rd=0, reg_write=0, illegal=0. Reset overrides in_valid in the same cycle.
- in_valid=0: next cycle out_valid=0, reg_write=0, illegal=0; result and rd hold their previous values.
- in_valid=1: next cycle out_valid=1 and all outputs reflect that instruction, including the illegal case.
- Back-to-back valid instructions each produce output exactly one cycle later, with no bubbles.
- Reset deasserted: the first valid output appears one cycle after the first in_valid=1 sampled with rst_n=1.

## Test plan
- Reset: rst_n=0 for 2 cycles with in_valid=1 -> all outputs 0. Release, apply ADD x3,x1,x2 with rs1=5, rs2=7 -> next cycle result=12, rd=3, reg_write=1, out_valid=1.
- SUB/SRA vs ADD/SRL:
  - SUB with rs1=0, rs2=1 -> result=0xFFFFFFFF.
  - SRA with rs1=0x80000000, rs2=4 -> 0xF8000000.
  - SRL with the same operands -> 0x08000000.
- OP-IMM:
  - ADDI with funct7 bits=0100000, rs1=10, imm=0xFFFFFFFF -> 9 (not SUB).
  - SLTI with rs1=0xFFFFFFFF, imm=1 -> 1.
  - SLTIU with the same operands -> 0.
  - SLLI with imm=0x21 -> shift by 1.
- Illegal and x0:
  - opcode 0000011 -> illegal=1, reg_write=0, result=0, out_valid=1.
  - OP with funct7=0000001 -> illegal=1.
  - ADD with rd=0 -> reg_write=0, result computed.
- Valid gating: alternate in_valid 1/0/1 with AND (0xF0F0, 0x0FF0 -> 0x00F0) and OR (-> 0xFFF0) -> out_valid pattern 1/0/1, result held at 0x00F0 during the gap.
- Back-to-back: 4 consecutive XOR, SLT, SLTU, SLL instructions -> outputs on 4 consecutive cycles, each matching a reference model.
